rx_udp: RTL

- Receive-path stage directly downstream of the IPv4 parser.
- Consumes the byte stream the IPv4 parser qualifies with rx_data_udp, which starts at the first byte after the IP header.
- Parses the 8-byte UDP header, filters on the local destination port, and emits the UDP payload bytes with valid/last strobes.
- Latches the source IP, source port and length for the application layer, and flags malformed or truncated datagrams.

---
 rtl/rx_udp.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_udp.sv
// UDP receive stage: sits behind the IPv4 parser, walks the 8-byte UDP
// header, filters on the local destination port and streams the payload
// with registered valid/last strobes. It also latches the source IP, source
// port and length for the application, and pulses on malformed or truncated
// datagrams.
module rx_udp #(
  parameter int OCT     = 8,
  parameter int HDR_LEN = 8
) (
  input  logic             RX_CLK,
  input  logic             rst,
  input  logic [2*OCT-1:0] port_num,
  input  logic [4*OCT-1:0] rx_src_ip,
  input  logic             rx_data_udp,
  input  logic [OCT-1:0]   rx_data,
  output logic [4*OCT-1:0] rx_udp_src_ip,
  output logic [2*OCT-1:0] rx_udp_src_port,
  output logic [2*OCT-1:0] rx_udp_len,
  output logic             rx_payload_valid,
  output logic [OCT-1:0]   rx_payload,
  output logic             rx_payload_last,
  output logic             rx_frame_done,
  output logic             rx_frame_err
);

  typedef enum logic [2:0] {
    IDLE,
    SRC_PORT,
    DST_PORT,
    LEN,
    CSUM,
    PAYLOAD,
    DROP
  } state_t;

  // Header length and the decrement step, sized to the 16-bit header fields.
  localparam logic [2*OCT-1:0] HdrLenW = (2*OCT)'(HDR_LEN);
  localparam logic [2*OCT-1:0] RemOne  = (2*OCT)'(1);

  state_t           state_q, state_d;
  logic             cnt_q, cnt_d;
  logic [OCT-1:0]   hi_q, hi_d;
  logic [2*OCT-1:0] rem_q, rem_d;
  logic [4*OCT-1:0] src_ip_q, src_ip_d;
  logic [2*OCT-1:0] src_port_q, src_port_d;
  logic [2*OCT-1:0] len_q, len_d;
  logic [2*OCT-1:0] csum_q, csum_d;
  logic [OCT-1:0]   payload_q, payload_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // A 16-bit header field completes when its second byte arrives; the first
  // byte is parked in hi_q, so the full field is the parked MSB plus this byte.
  logic [2*OCT-1:0] word;
  assign word = {hi_q, rx_data};

  // All state and output registers, cleared asynchronously by the reset.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 1'b0;
      hi_q       <= '0;
      rem_q      <= '0;
      src_ip_q   <= '0;
      src_port_q <= '0;
      len_q      <= '0;
      csum_q     <= '0;
      payload_q  <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      rem_q      <= rem_d;
      src_ip_q   <= src_ip_d;
      src_port_q <= src_port_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      payload_q  <= payload_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Header walk, port filter and payload countdown. Strobes default low each
  // cycle; latched fields hold unless a header field completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    rem_d      = rem_q;
    src_ip_d   = src_ip_q;
    src_port_d = src_port_q;
    len_d      = len_q;
    csum_d     = csum_q;
    payload_d  = payload_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_data_udp) begin
          // First byte of a datagram is the source port MSB.
          hi_d     = rx_data;
          src_ip_d = rx_src_ip;
          cnt_d    = 1'b1;
          state_d  = SRC_PORT;
        end
      end

      SRC_PORT, DST_PORT, LEN, CSUM: begin
        if (!rx_data_udp) begin
          // Strobe fell before the header finished: truncated datagram.
          err_d   = 1'b1;
          cnt_d   = 1'b0;
          state_d = IDLE;
        end else if (!cnt_q) begin
          hi_d  = rx_data;
          cnt_d = 1'b1;
        end else begin
          cnt_d = 1'b0;
          unique case (state_q)
            SRC_PORT: begin
              src_port_d = word;
              state_d    = DST_PORT;
            end
            DST_PORT: begin
              // Traffic for another port is dropped silently.
              state_d = (word == port_num) ? LEN : DROP;
            end
            LEN: begin
              len_d = word;
              if (word < HdrLenW) begin
                err_d   = 1'b1;
                state_d = DROP;
              end else begin
                rem_d   = word - HdrLenW;
                state_d = CSUM;
              end
            end
            default: begin
              // Checksum is recorded only; an empty payload completes here.
              csum_d = word;
              if (rem_q == '0) begin
                done_d  = 1'b1;
                state_d = DROP;
              end else begin
                state_d = PAYLOAD;
              end
            end
          endcase
        end
      end

      PAYLOAD: begin
        if (!rx_data_udp) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          payload_d = rx_data;
          valid_d   = 1'b1;
          rem_d     = rem_q - RemOne;
          if (rem_q == RemOne) begin
            // Final payload byte: anything after it is link padding.
            last_d  = 1'b1;
            done_d  = 1'b1;
            state_d = DROP;
          end
        end
      end

      DROP: begin
        if (!rx_data_udp) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign rx_udp_src_ip    = src_ip_q;
  assign rx_udp_src_port  = src_port_q;
  assign rx_udp_len       = len_q;
  assign rx_payload_valid = valid_q;
  assign rx_payload       = payload_q;
  assign rx_payload_last  = last_q;
  assign rx_frame_done    = done_q;
  assign rx_frame_err     = err_q;

endmodule
